// File: rtl/pic_intack_master_if.sv
// Host-side 8259A bus: chip select, address, strobes and the split data bus.
// The master modport is the host initiator; the slave modport is the PIC side.
interface pic_intack_master_if;
    logic       CS_n;
    logic       A0;
    logic       WR_n;
    logic       RD_n;
    logic       INTA_n;
    logic [7:0] D_out;
    logic       D_oe;
    logic       INT;
    logic [7:0] D_in;

    modport master (
        output CS_n, A0, WR_n, RD_n, INTA_n, D_out, D_oe,
        input  INT, D_in
    );

    modport slave (
        input  CS_n, A0, WR_n, RD_n, INTA_n, D_out, D_oe,
        output INT, D_in
    );
endinterface

// File: rtl/pic_intack_master.sv
// Host initiator for an 8259A-style PIC: ICW programming, two-pulse INTA
// vector fetch and non-specific EOI, all sequenced by one FSM.
module pic_intack_master #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    // Handshake: start_init and svc_done are single-cycle requests with no
    // ready; start_init is taken only in IDLE/READY and svc_done only in
    // VECWAIT, a request arriving in any other state is dropped.
    input  logic                       start_init,
    input  logic [7:0]                 cfg_icw1,
    input  logic [7:0]                 cfg_icw2,
    input  logic [7:0]                 cfg_icw3,
    input  logic [7:0]                 cfg_icw4,
    input  logic                       svc_done,
    output logic                       init_done,
    output logic                       vec_valid,
    output logic [7:0]                 vector,
    output logic                       busy,
    output logic [3:0]                 state_dbg,
    pic_intack_master_if.master        bus
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W_SETUP = 4'd1,
        W_PULSE = 4'd2,
        W_HOLD  = 4'd3,
        W_GAP   = 4'd4,
        READY   = 4'd5,
        ACK1    = 4'd6,
        ACKGAP  = 4'd7,
        ACK2    = 4'd8,
        VECWAIT = 4'd9,
        EOI     = 4'd10
    } state_t;

    // Which write the shared W_* states are carrying; also the return target.
    typedef enum logic [2:0] {
        PH_ICW1 = 3'd0,
        PH_ICW2 = 3'd1,
        PH_ICW3 = 3'd2,
        PH_ICW4 = 3'd3,
        PH_EOI  = 3'd4
    } phase_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_W - 1);

    state_t     state, state_n;
    phase_t     phase, phase_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
    logic       aeoi;
    logic       accept, capture, init_fin;
    logic [7:0] wr_data;
    logic       wr_a0;
    logic       cs_active;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            phase     <= PH_ICW1;
            cnt       <= '0;
            icw1_q    <= '0;
            icw2_q    <= '0;
            icw3_q    <= '0;
            icw4_q    <= '0;
            aeoi      <= 1'b0;
            init_done <= 1'b0;
            vector    <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            cnt   <= cnt_n;
            if (accept) begin
                icw1_q    <= cfg_icw1;
                icw2_q    <= cfg_icw2;
                icw3_q    <= cfg_icw3;
                icw4_q    <= cfg_icw4;
                aeoi      <= cfg_icw1[0] & cfg_icw4[1];
                init_done <= 1'b0;
            end else if (init_fin) begin
                init_done <= 1'b1;
            end
            if (capture) begin
                vector <= bus.D_in;
            end
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        accept   = 1'b0;
        capture  = 1'b0;
        init_fin = 1'b0;
        case (state)
            IDLE: begin
                if (start_init) begin
                    accept  = 1'b1;
                    phase_n = PH_ICW1;
                    state_n = W_SETUP;
                end
            end
            READY: begin
                if (start_init) begin
                    accept  = 1'b1;
                    phase_n = PH_ICW1;
                    state_n = W_SETUP;
                end else if (bus.INT) begin
                    state_n = ACK1;
                end
            end
            W_SETUP: state_n = W_PULSE;
            W_PULSE: if (cnt == PULSE_LAST) state_n = W_HOLD;
            W_HOLD:  state_n = W_GAP;
            W_GAP: begin
                if (cnt == GAP_LAST) begin
                    // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1.
                    case (phase)
                        PH_ICW1: begin
                            phase_n = PH_ICW2;
                            state_n = W_SETUP;
                        end
                        PH_ICW2: begin
                            if (!icw1_q[1]) begin
                                phase_n = PH_ICW3;
                                state_n = W_SETUP;
                            end else if (icw1_q[0]) begin
                                phase_n = PH_ICW4;
                                state_n = W_SETUP;
                            end else begin
                                init_fin = 1'b1;
                                state_n  = READY;
                            end
                        end
                        PH_ICW3: begin
                            if (icw1_q[0]) begin
                                phase_n = PH_ICW4;
                                state_n = W_SETUP;
                            end else begin
                                init_fin = 1'b1;
                                state_n  = READY;
                            end
                        end
                        PH_ICW4: begin
                            init_fin = 1'b1;
                            state_n  = READY;
                        end
                        default: state_n = READY;
                    endcase
                end
            end
            ACK1:   if (cnt == PULSE_LAST) state_n = ACKGAP;
            ACKGAP: if (cnt == GAP_LAST) state_n = ACK2;
            ACK2: begin
                if (cnt == PULSE_LAST) begin
                    capture = 1'b1;
                    state_n = VECWAIT;
                end
            end
            VECWAIT: if (svc_done) state_n = EOI;
            EOI: begin
                if (aeoi) begin
                    state_n = READY;
                end else begin
                    phase_n = PH_EOI;
                    state_n = W_SETUP;
                end
            end
            default: state_n = IDLE;
        endcase
        // Counter restarts on every state change, so each timed state sees 0 first.
        cnt_n = (state_n != state) ? 8'd0 : cnt + 8'd1;
    end

    always_comb begin
        wr_data = 8'h20;
        wr_a0   = 1'b0;
        case (phase)
            PH_ICW1: begin
                wr_data = {icw1_q[7:5], 1'b1, icw1_q[3:0]};
                wr_a0   = 1'b0;
            end
            PH_ICW2: begin
                wr_data = icw2_q;
                wr_a0   = 1'b1;
            end
            PH_ICW3: begin
                wr_data = icw3_q;
                wr_a0   = 1'b1;
            end
            PH_ICW4: begin
                wr_data = icw4_q;
                wr_a0   = 1'b1;
            end
            default: begin
                wr_data = 8'h20;
                wr_a0   = 1'b0;
            end
        endcase
    end

    // Bus outputs decode straight from the state register so RESET drops them at once.
    assign cs_active  = (state == W_SETUP) || (state == W_PULSE) || (state == W_HOLD);
    assign bus.CS_n   = ~cs_active;
    assign bus.A0     = cs_active & wr_a0;
    assign bus.WR_n   = ~(state == W_PULSE);
    assign bus.RD_n   = 1'b1;
    assign bus.INTA_n = ~((state == ACK1) || (state == ACK2));
    assign bus.D_out  = cs_active ? wr_data : 8'h00;
    assign bus.D_oe   = cs_active;

    assign vec_valid = (state == VECWAIT);
    assign busy      = !((state == IDLE) || (state == READY) || (state == VECWAIT));
    assign state_dbg = state;

endmodule

// File: doc/pic_intack_master.md
Name: pic_intack_master

Overview:
- Host/CPU-side initiator for the 8259A-compatible PIC; the other end of the PIC's WR/INTA/data-bus protocol.
- After a start request, writes the configured ICW1..ICW4 sequence to the PIC.
- Then services interrupts: on INT it drives the two-pulse INTA cycle, captures the vector from the PIC bus on the second pulse and presents it to the core.
- After the core signals completion, writes a non-specific EOI (OCW2 = 8'h20), unless the PIC is configured for AEOI.

Parameters:
PULSE_W, 2, cycles each WR_n/INTA_n low pulse lasts (>=1)
GAP_W, 2, idle cycles between the two INTA pulses and after every bus cycle (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
start_init  in  1  single-cycle request to run the ICW sequence
cfg_icw1  in  8  ICW1 value (bit4 is forced to 1 on the bus)
cfg_icw2  in  8  ICW2 value (vector base in [7:3])
cfg_icw3  in  8  ICW3 value
cfg_icw4  in  8  ICW4 value
INT  in  1  interrupt request from PIC, active high
D_in  in  8  PIC data bus as read by host
svc_done  in  1  core finished the ISR; single-cycle pulse
CS_n  out  1  PIC chip select, active low
A0  out  1  PIC address bit
WR_n  out  1  write strobe, active low
RD_n  out  1  read strobe; tied high (1) in this block
INTA_n  out  1  interrupt acknowledge, active low
D_out  out  8  write data to PIC
D_oe  out  1  1 = host drives D_out onto the bus
init_done  out  1  ICW sequence complete
vec_valid  out  1  vector held, awaiting svc_done
vector  out  8  captured interrupt vector
busy  out  1  any bus cycle or INTA sequence in progress

Behaviour:
- Reset values:
  - CS_n = 1, A0 = 0, WR_n = 1, RD_n = 1, INTA_n = 1.
  - D_out = 0, D_oe = 0, init_done = 0, vec_valid = 0, vector = 0, busy = 0.
  - FSM in IDLE.
- Reset mid-operation: all strobes deassert immediately (asynchronous); a partial ICW sequence is abandoned and init_done = 0.
- Write cycle (shared by ICW and EOI), total 2+PULSE_W+GAP_W cycles:
  - SETUP, 1 cycle: CS_n = 0, A0 and D_out valid, D_oe = 1.
  - WR_n = 0 for PULSE_W cycles.
  - HOLD, 1 cycle: WR_n = 1, CS_n = 0, D_oe = 1.
  - GAP_W cycles with CS_n = 1 and D_oe = 0.
- Init sequence:
  - Start: start_init accepted in IDLE or READY. Acceptance clears init_done and vec_valid.
  - ICW1: A0 = 0, data {cfg_icw1[7:5], 1'b1, cfg_icw1[3:0]}.
  - ICW2: A0 = 1, data cfg_icw2.
  - ICW3: A0 = 1, data cfg_icw3; sent only if cfg_icw1[1] = 0 (cascade).
  - ICW4: A0 = 1, data cfg_icw4; sent only if cfg_icw1[0] = 1.
  - Latching: cfg_* values are latched at acceptance; later changes do not affect the running sequence.
  - Completion: init_done rises 1 cycle after the final GAP, and the FSM enters READY.
  - AEOI flag: set if cfg_icw1[0] = 1 and cfg_icw4[1] = 1, otherwise cleared.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, W_GAP, READY, ACK1, ACKGAP, ACK2, VECWAIT, EOI (reuses W_* states with return target).
- Interrupt acknowledge:
  - Trigger: in READY with INT = 1 (sampled), the FSM goes to ACK1 and busy = 1.
  - ACK1: INTA_n = 0 for PULSE_W cycles.
  - ACKGAP: INTA_n = 1 for GAP_W cycles.
  - ACK2: INTA_n = 0 for PULSE_W cycles. D_in is sampled on the last ACK2 cycle into vector.
  - After ACK2: INTA_n = 1 next cycle, vec_valid = 1, FSM enters VECWAIT.
  - D_oe = 0 and CS_n = 1 throughout the INTA cycle.
  - The sequence runs to completion even if INT drops after ACK1 starts. A PIC spurious vector is captured as-is.
- VECWAIT: hold vector and vec_valid until svc_done = 1. In the cycle after svc_done, vec_valid = 0.
  - If AEOI = 1: return to READY.
  - If AEOI = 0: run a write cycle with A0 = 0, data 8'h20, then return to READY.
- svc_done outside VECWAIT is ignored.
- INT is ignored in IDLE and during any init or EOI write.
- Simultaneous events in READY: start_init has priority over INT.
- The next INT is sampled no earlier than the first READY cycle after the EOI gap.
- busy = 1 in every state except IDLE, READY and VECWAIT.

Test Plan:
1. Init, single mode with ICW4: RESET, then start_init with icw1 = 8'h13, icw2 = 8'h40, icw4 = 8'h01 -> exactly 3 WR_n pulses: A0/data = 0/8'h13, 1/8'h40, 1/8'h01; no ICW3; init_done = 1; AEOI = 0.
2. Init, cascade without ICW4: icw1 = 8'h00, icw3 = 8'h04 -> writes 0/8'h10 (bit4 forced), 1/icw2, 1/8'h04; only 3 writes.
3. INTA cycle: after case 1, assert INT and drive D_in = 8'h45 during ACK2 -> INTA_n goes low twice for 2 cycles each, 2 high cycles between; vector = 8'h45; vec_valid = 1; no WR_n activity.
4. EOI: svc_done pulse in VECWAIT -> vec_valid = 0 next cycle, then one write A0 = 0, D_out = 8'h20, then READY; svc_done pulses outside VECWAIT produce no writes.
5. AEOI: init with icw4 = 8'h03, run an interrupt, pulse svc_done -> no WR_n pulse; return to READY.
6. RESET asserted during ACK2 and during an ICW2 write -> INTA_n/WR_n high and CS_n = 1 within the same cycle; init_done = 0; FSM in IDLE; a new INT is ignored until re-init.
